// File: rtl/snake_pkg.sv
// Direction codes and helpers shared by the snake direction controller and the motion block.
package snake_pkg;

    localparam int unsigned NUM_BTN = 4;

    typedef enum logic [1:0] {
        DIR_YINC = 2'd0,
        DIR_YDEC = 2'd1,
        DIR_XDEC = 2'd2,
        DIR_XINC = 2'd3
    } dir_t;

    // Opposite directions differ only in the LSB: 0<->1, 2<->3.
    function automatic dir_t dir_opposite(input dir_t d);
        return dir_t'(d ^ 2'b01);
    endfunction

endpackage

// File: rtl/snake_btn_debounce.sv
// One push-button lane: 2-flop synchroniser, saturating debounce counter,
// debounced level and a registered one-cycle rising-edge pulse.
module snake_btn_debounce #(
    parameter int unsigned DB_CYCLES = 50000,
    parameter int unsigned DB_CNT_W  = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_async,
    output logic rise
);

    localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DB_CYCLES - 1);
    localparam logic [DB_CNT_W-1:0] CNT_ONE  = DB_CNT_W'(1);

    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic                level_q, level_d;
    logic                prev_q,  prev_d;
    logic                rise_q,  rise_d;
    logic [DB_CNT_W-1:0] cnt_q,   cnt_d;

    always_comb begin
        sync1_d = btn_async;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync2_q != level_q) begin
            if (cnt_q >= CNT_LAST) begin
                level_d = sync2_q;
                cnt_d   = '0;
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = '0;
        end
        // Edge is taken between the level and its delayed copy so the pulse is registered.
        prev_d = level_q;
        rise_d = level_q & ~prev_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            prev_q  <= prev_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/snake_dir_ctrl.sv
// Turns four raw buttons into the committed snake direction: debounce, press priority,
// U-turn rejection and a pending request that commits on the step pulse.
module snake_dir_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 50000,
    parameter int unsigned DB_CNT_W  = 16,
    parameter logic [1:0]  INIT_DIR  = 2'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn,
    input  logic       step,
    output logic [1:0] control,
    output logic       pend_vld,
    output logic       reject
);

    logic [NUM_BTN-1:0] rise;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        snake_btn_debounce #(
            .DB_CYCLES (DB_CYCLES),
            .DB_CNT_W  (DB_CNT_W)
        ) u_db (
            .clk       (clk),
            .rst       (rst),
            .btn_async (btn[i]),
            .rise      (rise[i])
        );
    end

    dir_t control_q, control_d;
    dir_t pend_q,    pend_d;
    logic pend_vld_q, pend_vld_d;
    logic reject_q,   reject_d;

    logic press;
    dir_t press_dir;
    dir_t ref_dir;
    logic commit;

    // Button index equals its direction code; scanning downward lets the lowest index win.
    always_comb begin
        press     = |rise;
        press_dir = DIR_YINC;
        for (int unsigned i = NUM_BTN; i > 0; i--) begin
            if (rise[i-1]) begin
                press_dir = dir_t'(2'(i - 1));
            end
        end
    end

    always_comb begin
        commit     = step && pend_vld_q;
        ref_dir    = commit ? pend_q : control_q;
        control_d  = control_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        reject_d   = 1'b0;
        if (commit) begin
            control_d  = pend_q;
            pend_vld_d = 1'b0;
        end
        // A press in the step cycle is judged against the freshly committed direction.
        if (press) begin
            if (press_dir == dir_opposite(ref_dir)) begin
                reject_d = 1'b1;
            end else if (press_dir != ref_dir) begin
                pend_d     = press_dir;
                pend_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            control_q  <= dir_t'(INIT_DIR);
            pend_q     <= DIR_YINC;
            pend_vld_q <= 1'b0;
            reject_q   <= 1'b0;
        end else begin
            control_q  <= control_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            reject_q   <= reject_d;
        end
    end

    assign control  = control_q;
    assign pend_vld = pend_vld_q;
    assign reject   = reject_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Directed bench for snake_dir_ctrl with a short debounce window (DB_CYCLES=4).
module tb_snake_dir_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn;
    logic       step;
    logic [1:0] control;
    logic       pend_vld;
    logic       reject;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    snake_dir_ctrl #(
        .DB_CYCLES (4),
        .DB_CNT_W  (4),
        .INIT_DIR  (2'd0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn      (btn),
        .step     (step),
        .control  (control),
        .pend_vld (pend_vld),
        .reject   (reject)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Press a direction button long enough to latch, then commit it with a step pulse.
    task automatic go_dir(input logic [1:0] code);
        btn = 4'b0001 << code;
        tick(8);
        check_eq("go_dir pend_vld", 32'(pend_vld), 32'd1);
        btn  = 4'b0000;
        step = 1'b1;
        tick(1);
        step = 1'b0;
        check_eq("go_dir control", 32'(control), 32'(code));
        tick(8);
    endtask

    logic saw_pend;

    initial begin
        rst  = 1'b1;
        btn  = 4'b0000;
        step = 1'b0;

        // 1: reset
        tick(2);
        rst = 1'b0;
        check_eq("rst control", 32'(control), 32'd0);
        check_eq("rst pend_vld", 32'(pend_vld), 32'd0);
        check_eq("rst reject", 32'(reject), 32'd0);

        // 2: latency of a held X_INC press, then commit
        btn = 4'b1000;
        tick(7);
        check_eq("lat pend_vld early", 32'(pend_vld), 32'd0);
        tick(1);
        check_eq("lat pend_vld", 32'(pend_vld), 32'd1);
        check_eq("lat control held", 32'(control), 32'd0);
        tick(2);
        btn  = 4'b0000;
        step = 1'b1;
        tick(1);
        step = 1'b0;
        check_eq("step control", 32'(control), 32'd3);
        check_eq("step pend_vld", 32'(pend_vld), 32'd0);
        tick(8);

        // 3: U-turn rejection from control=0, then same-direction press ignored
        go_dir(2'd0);
        btn = 4'b0010;
        tick(7);
        check_eq("uturn reject early", 32'(reject), 32'd0);
        tick(1);
        check_eq("uturn reject", 32'(reject), 32'd1);
        check_eq("uturn pend_vld", 32'(pend_vld), 32'd0);
        tick(1);
        check_eq("uturn reject width", 32'(reject), 32'd0);
        btn  = 4'b0000;
        step = 1'b1;
        tick(1);
        step = 1'b0;
        check_eq("uturn control", 32'(control), 32'd0);
        tick(8);
        btn = 4'b0001;
        tick(8);
        check_eq("same pend_vld", 32'(pend_vld), 32'd0);
        check_eq("same reject", 32'(reject), 32'd0);
        btn = 4'b0000;
        tick(8);

        // 4: bouncing button never stable long enough
        saw_pend = 1'b0;
        for (int i = 0; i < 10; i++) begin
            btn = 4'b0100;
            tick(1);
            saw_pend |= pend_vld;
            tick(1);
            saw_pend |= pend_vld;
            btn = 4'b0000;
            tick(1);
            saw_pend |= pend_vld;
            tick(1);
            saw_pend |= pend_vld;
        end
        tick(8);
        check_eq("bounce pend seen", 32'(saw_pend), 32'd0);
        check_eq("bounce pend_vld", 32'(pend_vld), 32'd0);
        check_eq("bounce control", 32'(control), 32'd0);

        // 5: simultaneous X_DEC and X_INC, lower index wins
        btn = 4'b1100;
        tick(8);
        check_eq("prio pend_vld", 32'(pend_vld), 32'd1);
        btn  = 4'b0000;
        step = 1'b1;
        tick(1);
        step = 1'b0;
        check_eq("prio control", 32'(control), 32'd2);
        tick(8);

        // 6: press lands in the step cycle and is judged against the committed value
        go_dir(2'd0);
        btn = 4'b1000;
        tick(8);
        check_eq("pend3 pend_vld", 32'(pend_vld), 32'd1);
        btn = 4'b0000;
        tick(8);
        btn = 4'b0100;
        tick(7);
        step = 1'b1;
        tick(1);
        step = 1'b0;
        check_eq("samecyc control", 32'(control), 32'd3);
        check_eq("samecyc reject", 32'(reject), 32'd1);
        check_eq("samecyc pend_vld", 32'(pend_vld), 32'd0);
        tick(1);
        check_eq("samecyc reject width", 32'(reject), 32'd0);
        btn = 4'b0000;
        tick(8);
        btn = 4'b0001;
        tick(8);
        check_eq("prerst pend_vld", 32'(pend_vld), 32'd1);
        btn = 4'b0000;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_eq("midrst pend_vld", 32'(pend_vld), 32'd0);
        check_eq("midrst control", 32'(control), 32'd0);
        check_eq("midrst reject", 32'(reject), 32'd0);

        // 7: button held through reset is accepted once debounced afterwards
        btn = 4'b0100;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(7);
        check_eq("held pend_vld early", 32'(pend_vld), 32'd0);
        tick(1);
        check_eq("held pend_vld", 32'(pend_vld), 32'd1);
        btn = 4'b0000;
        tick(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d checks done", n_checks);
        $fatal(1);
    end

endmodule
